// File: rtl/bloom_lut_pkg.sv
// Shared types and helpers for the Bloom engine LUT bank.
package bloom_lut_pkg;

  localparam int CFG_DATA_W = 8;

  typedef enum logic {IDLE, CLEAR} lut_state_t;

  // Array-select width; never narrower than one bit so a single array still decodes.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bloom_lut_ram.sv
// 2^HASH_W x 1 dual-port bit array: port A registered lookup read, port B write
// (plus registered read when BLOOM_LUT_READBACK_EN is defined). Old data on collision.
module bloom_lut_ram #(
  parameter int HASH_W = 12
) (
  input  logic              clk_i,
  input  logic [HASH_W-1:0] a_addr,
  output logic              a_q,
  input  logic [HASH_W-1:0] b_addr,
  input  logic              b_we,
  input  logic              b_wd
`ifdef BLOOM_LUT_READBACK_EN
  ,
  output logic              b_q
`endif
);

  logic mem [0:(2**HASH_W)-1];

  always_ff @(posedge clk_i) begin
    a_q <= mem[a_addr];
    if (b_we) mem[b_addr] <= b_wd;
  end

`ifdef BLOOM_LUT_READBACK_EN
  always_ff @(posedge clk_i) b_q <= mem[b_addr];
`endif

endmodule

// File: rtl/bloom_hash_lut_bank.sv
// Bloom LUT responder: HASHES_CNT bit-arrays, 1-cycle parallel lookups, Avalon-MM
// host bit access and a clear sweep. Host readback enabled by BLOOM_LUT_READBACK_EN.
module bloom_hash_lut_bank
  import bloom_lut_pkg::*;
#(
  parameter int HASHES_CNT = 6,
  parameter int HASH_W     = 12,
  parameter int IDX_W      = idx_w(HASHES_CNT)
) (
  input  logic                         clk_i,
  input  logic                         srst_i,
  input  logic [HASHES_CNT*HASH_W-1:0] lut_address_i,
  output logic [HASHES_CNT-1:0]        lut_readdata_o,
  input  logic [IDX_W+HASH_W-1:0]      amm_slave_address_i,
  input  logic                         amm_slave_write_i,
  input  logic [CFG_DATA_W-1:0]        amm_slave_writedata_i,
  input  logic                         amm_slave_read_i,
  output logic [CFG_DATA_W-1:0]        amm_slave_readdata_o,
  output logic                         amm_slave_readdatavalid_o,
  output logic                         amm_slave_waitrequest_o,
  input  logic                         clear_i,
  output logic                         clear_busy_o
);

  lut_state_t            state_q, state_d;
  logic [HASH_W-1:0]     clr_cnt_q, clr_cnt_d;
  logic [HASHES_CNT-1:0] lk_q;
  logic                  lk_zero_q;
  logic [IDX_W-1:0]      host_idx;
  logic [HASH_W-1:0]     host_addr, b_addr;
  logic                  clearing, host_wr, b_wd;
  logic                  unused_ok;

  assign {host_idx, host_addr} = amm_slave_address_i;
  assign clearing = (state_q == CLEAR);
  assign host_wr  = !clearing && amm_slave_write_i;
  assign b_addr   = clearing ? clr_cnt_q : host_addr;
  assign b_wd     = !clearing && amm_slave_writedata_i[0];
  assign unused_ok = ^{amm_slave_writedata_i[CFG_DATA_W-1:1], amm_slave_read_i};

  assign amm_slave_waitrequest_o = clearing;
  assign clear_busy_o            = clearing;

  // lk_zero_q hides lookups issued during the sweep (array contents still in flux).
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      lk_zero_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      lk_zero_q <= clearing;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (&clr_cnt_q) state_d = IDLE;
      end
      default: begin
        if (clear_i) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
    endcase
  end

`ifdef BLOOM_LUT_READBACK_EN
  logic [HASHES_CNT-1:0] b_q;
`endif

  for (genvar h = 0; h < HASHES_CNT; h++) begin : g_arr
    bloom_lut_ram #(.HASH_W(HASH_W)) u_ram (
      .clk_i  (clk_i),
      .a_addr (lut_address_i[h*HASH_W +: HASH_W]),
      .a_q    (lk_q[h]),
      .b_addr (b_addr),
      .b_we   (clearing || (host_wr && host_idx == IDX_W'(h))),
      .b_wd   (b_wd)
`ifdef BLOOM_LUT_READBACK_EN
      ,
      .b_q    (b_q[h])
`endif
    );
  end

  assign lut_readdata_o = lk_zero_q ? '0 : lk_q;

`ifdef BLOOM_LUT_READBACK_EN
  localparam int NSEL = 2**IDX_W;
  logic [NSEL-1:0]  b_q_pad;
  logic             rd_vld_q;
  logic [IDX_W-1:0] rd_idx_q;

  // Zero-padding makes out-of-range array indices read back as 0.
  assign b_q_pad = NSEL'(b_q);

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      rd_vld_q <= 1'b0;
      rd_idx_q <= '0;
    end else begin
      rd_vld_q <= !clearing && amm_slave_read_i && !amm_slave_write_i;
      rd_idx_q <= host_idx;
    end
  end

  assign amm_slave_readdatavalid_o = rd_vld_q;
  assign amm_slave_readdata_o      = {{(CFG_DATA_W-1){1'b0}}, rd_vld_q & b_q_pad[rd_idx_q]};
`else
  assign amm_slave_readdatavalid_o = 1'b0;
  assign amm_slave_readdata_o      = '0;
`endif

endmodule

// File: tb/tb_bloom_hash_lut_bank.sv
// Randomized + directed bench for bloom_hash_lut_bank against a bit-array model.
module tb_bloom_hash_lut_bank;
  localparam int HC = 6, HW = 12, IW = 3, DEPTH = 1 << HW;

  logic              clk = 1'b0;
  logic              srst = 1'b1;
  logic [HC*HW-1:0]  lut_addr = '0;
  logic [HC-1:0]     lut_rd;
  logic [IW+HW-1:0]  amm_addr = '0;
  logic              amm_wr = 1'b0, amm_rd = 1'b0, clr = 1'b0;
  logic [7:0]        amm_wd = '0, amm_rdata;
  logic              amm_rv, amm_wait, busy;

  always #5 clk = ~clk;

  bloom_hash_lut_bank #(.HASHES_CNT(HC), .HASH_W(HW)) dut (
    .clk_i                     (clk),
    .srst_i                    (srst),
    .lut_address_i             (lut_addr),
    .lut_readdata_o            (lut_rd),
    .amm_slave_address_i       (amm_addr),
    .amm_slave_write_i         (amm_wr),
    .amm_slave_writedata_i     (amm_wd),
    .amm_slave_read_i          (amm_rd),
    .amm_slave_readdata_o      (amm_rdata),
    .amm_slave_readdatavalid_o (amm_rv),
    .amm_slave_waitrequest_o   (amm_wait),
    .clear_i                   (clr),
    .clear_busy_o              (busy)
  );

  always @(posedge clk) assert (!(amm_wr && amm_rd)) else $error("host drove write and read together");

  bit mem [HC][DEPTH];
  int clr_left;
  int n_chk = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wipe();
    for (int h = 0; h < HC; h++)
      for (int a = 0; a < DEPTH; a++) mem[h][a] = 1'b0;
  endtask

  task automatic set_lk(input int h, input int a);
    lut_addr[h*HW +: HW] = a[HW-1:0];
  endtask

  task automatic set_all_lk(input int a);
    for (int h = 0; h < HC; h++) set_lk(h, a);
  endtask

  task automatic host(input bit w, input bit r, input int idx, input int a, input int d);
    amm_wr   = w;
    amm_rd   = r;
    amm_addr = {idx[IW-1:0], a[HW-1:0]};
    amm_wd   = d[7:0];
  endtask

  // One clock: predict from the model state before the edge, update model, check after.
  task automatic cyc();
    logic [HC-1:0] e_lk;
    logic e_rv, e_rb;
    bit bz;
    int idx, ba;
    bz  = clr_left > 0;
    idx = int'(amm_addr[IW+HW-1:HW]);
    ba  = int'(amm_addr[HW-1:0]);
    for (int h = 0; h < HC; h++) e_lk[h] = bz ? 1'b0 : mem[h][lut_addr[h*HW +: HW]];
    e_rv = 1'b0;
    e_rb = 1'b0;
`ifdef BLOOM_LUT_READBACK_EN
    e_rv = !bz && amm_rd && !amm_wr;
    e_rb = (e_rv && idx < HC) ? mem[idx][ba] : 1'b0;
`endif
    if (!bz && amm_wr && idx < HC) mem[idx][ba] = amm_wd[0];
    if (bz) clr_left--;
    else if (clr) begin
      clr_left = DEPTH;
      wipe();
    end
    @(posedge clk); #1;
    check("lookup", lut_rd, e_lk);
    check("rvalid", amm_rv, e_rv);
`ifdef BLOOM_LUT_READBACK_EN
    if (e_rv) check("rdata", amm_rdata, {7'b0, e_rb});
`else
    check("rdata", amm_rdata, 0);
`endif
    check("busy", busy, clr_left > 0);
    check("waitreq", amm_wait, clr_left > 0);
  endtask

  task automatic do_reset(input int n);
    srst = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
    srst = 1'b0;
    clr_left = DEPTH;
    wipe();
    check("rst_lookup", lut_rd, 0);
    check("rst_rvalid", amm_rv, 0);
    check("rst_rdata", amm_rdata, 0);
    check("rst_busy", busy, 1);
    check("rst_waitreq", amm_wait, 1);
  endtask

  task automatic run_sweep(input string tag);
    int n;
    n = 0;
    while (busy && n < DEPTH + 8) begin
      cyc();
      n++;
    end
    check(tag, n, DEPTH);
  endtask

  task automatic rand_phase(input int cycles);
    int op;
    for (int i = 0; i < cycles; i++) begin
      op = $urandom_range(0, 3);
      for (int h = 0; h < HC; h++) set_lk(h, $urandom_range(0, 15));
      case (op)
        0: host(1, 0, $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 255));
        1: host(0, 1, $urandom_range(0, 7), $urandom_range(0, 15), 0);
        default: host(0, 0, 0, 0, 0);
      endcase
      cyc();
    end
    host(0, 0, 0, 0, 0);
  endtask

  initial begin
    wipe();
    clr_left = DEPTH;
    // 1: reset, full sweep, then lookups read 0
    do_reset(3);
    for (int h = 0; h < HC; h++) set_lk(h, $urandom_range(0, DEPTH - 1));
    run_sweep("init_sweep_len");
    repeat (8) begin
      for (int h = 0; h < HC; h++) set_lk(h, $urandom_range(0, DEPTH - 1));
      cyc();
    end
    // 2: single bit write, visible next cycle only on its own port
    host(1, 0, 2, 'h0A5, 1);
    cyc();
    host(0, 0, 0, 0, 0);
    set_all_lk('h0A5);
    cyc();
    check("t2_single_bit", lut_rd, 6'b000100);
    // same-cycle write/lookup collision returns old value, then the new one
    host(1, 0, 0, 'h077, 1);
    set_all_lk('h077);
    cyc();
    check("collision_old", lut_rd, 0);
    host(0, 0, 0, 0, 0);
    cyc();
    check("collision_new", lut_rd, 6'b000001);
    // 3: engine match on all arrays
    for (int h = 0; h < HC; h++) begin
      host(1, 0, h, 'h010, 1);
      cyc();
    end
    host(0, 0, 0, 0, 0);
    set_all_lk('h010);
    cyc();
    check("t3_match_all", lut_rd, 6'h3F);
    rand_phase(400);
    // 4: clear with a same-cycle write; held host write lands after the sweep
    host(1, 0, 1, 'h005, 1);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    host(1, 0, 4, 'h033, 1);
    set_all_lk('h010);
    run_sweep("clear_sweep_len");
    cyc();
    host(0, 0, 0, 0, 0);
    set_all_lk('h010);
    set_lk(4, 'h033);
    set_lk(1, 'h005);
    cyc();
    check("t4_after_clear", lut_rd, 6'b010000);
    // 5: out-of-range array index is dropped
    host(1, 0, 7, 'h0A6, 1);
    cyc();
    host(1, 0, 6, 'h0A6, 1);
    cyc();
    host(0, 0, 0, 0, 0);
    set_all_lk('h0A6);
    cyc();
    check("t5_idx_oob", lut_rd, 0);
    host(1, 0, 2, 'h0A5, 1);
    cyc();
    host(0, 1, 2, 'h0A5, 0);
    cyc();
`ifdef BLOOM_LUT_READBACK_EN
    check("t5_rb_valid", amm_rv, 1);
    check("t5_rb_data", amm_rdata, 8'h01);
`else
    check("t5_rb_tied", amm_rv, 0);
`endif
    host(0, 1, 7, 'h0A5, 0);
    cyc();
    host(0, 0, 0, 0, 0);
    rand_phase(300);
    // 6: reset mid-sweep restarts the full sweep
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    repeat (100) cyc();
    do_reset(1);
    run_sweep("restart_sweep_len");
    rand_phase(200);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
